wb_scheduler: RTL
=================

WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 Parameter: RR_EN, default 1, meaning 1 = round-robin ALU/LSU arbitration, 0 = fixed ALU priority.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 iss_valid  in  1  decode presents an instruction for issue.
REQ-005 iss_rd / iss_rs1 / iss_rs2  in  `R_MSB+1 each  destination and source register indices.
REQ-006 iss_ready  out  1  combinational; no hazard, issue may fire.
REQ-007 alu_valid, lsu_valid  in  1 each  writeback request from ALU / load unit.
REQ-008 alu_rd, lsu_rd  in  `R_MSB+1 each  writeback destination index.
REQ-009 alu_data, lsu_data  in  `XBUS each  writeback value.
REQ-010 alu_ready, lsu_ready  out  1 each  combinational grant; the request is consumed on valid&ready.
REQ-011 wr_en  out  1  registered register-file write enable.
REQ-012 wr_addr  out  `R_MSB+1  registered register-file write address.
REQ-013 wr_data  out  `XBUS  registered register-file write data.
REQ-014 wb_err  out  1  sticky flag; writeback to a register that is not busy.

Function
REQ-015 Scoreboard: busy bits for registers 1..`R_LAST; register 0 SHALL never read as busy.
REQ-016 iss_ready = !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]), independent of iss_valid.
REQ-017 Issue fire = iss_valid & iss_ready; when iss_rd != 0, busy[iss_rd] SHALL be set at that posedge.
REQ-018 Arbitration: at most one of alu_ready/lsu_ready is high per cycle; a single valid requester is granted in the same cycle.
REQ-019 Both valid, RR_EN=1: grant the source not granted most recently; pointer updates only on a grant; after reset the pointer favours ALU.
REQ-020 Both valid, RR_EN=0: always grant ALU.
REQ-021 Latency: a grant in cycle N SHALL produce wr_en=1, wr_addr=rd, wr_data=data in cycle N+1.
REQ-022 A grant with rd == 0 SHALL be consumed with wr_en=0 in N+1, no scoreboard change and no wb_err.
REQ-023 busy[wr_addr] SHALL clear at the posedge ending the cycle in which wr_en=1, which is the edge the register file commits; iss_ready for a dependent instruction therefore rises no earlier than N+2.
REQ-024 Because busy[rd] blocks issue, set and clear of the same index cannot coincide; set and clear of different indices in one cycle SHALL both take effect.
REQ-025 If a granted rd != 0 is not busy at grant time, the write SHALL still occur and wb_err SHALL set and stay set until reset.
REQ-026 With no grant in cycle N, wr_en SHALL be 0 in N+1; wr_addr/wr_data hold their previous values.

Reset
REQ-027 rst=1 SHALL immediately clear all busy bits, wr_en, wr_addr, wr_data and wb_err, and set the RR pointer to ALU.
REQ-028 A write registered but not yet committed when rst asserts SHALL be dropped, with no register-file write.
REQ-029 During reset, alu_ready and lsu_ready SHALL be 0; iss_ready SHALL be 1 (scoreboard empty).

Structure
REQ-030 Index width, data width and register count SHALL come from `R_MSB, `R_LAST, `R_COUNT and `XBUS in defs.v; no local redefinition.
REQ-031 The 2-way round-robin arbiter SHALL be a sub-module named wb_rr_arb (valid in x2, grant out x2, clk, rst, RR_EN).
REQ-032 The scoreboard, writeback register and error flag SHALL live in wb_scheduler.

Verification
REQ-033 Issue rd=5 -> busy[5]=1; issue rs1=5 blocked; ALU wb rd=5 data=0xDEAD granted cycle N -> wr_en/addr 5/0xDEAD in N+1 -> iss_ready=1 in N+2.
REQ-034 RR_EN=1, ALU and LSU both valid for 4 cycles (rd 3 and rd 4, both busy) -> grants ALU, LSU, ALU, LSU; RR_EN=0 -> ALU four times.
REQ-035 LSU wb rd=0, data=0x1234 -> lsu_ready=1, wr_en=0 next cycle, wb_err=0.
REQ-036 ALU wb rd=7 with busy[7]=0 -> register 7 written, wb_err=1 and held until rst.
REQ-037 Grant to rd=9 in cycle N, rst pulsed in N+1 before the edge -> no write to register 9, all busy bits 0, iss_ready=1.
REQ-038 Issue rd=2 in the same cycle wr_en=1 for addr 6 -> busy[2]=1 and busy[6]=0 after the edge.

Source files
------------

// File: rtl/wb_scheduler_pkg.sv
// wb_scheduler_pkg: shared types and helpers for the writeback scheduler.
// Widths come from the project-wide macros R_MSB, R_LAST, R_COUNT and XBUS
// (the defs.v set). The guarded fallback below applies only when defs.v has
// not already been read into the same compilation unit.
`ifndef R_MSB
`define R_MSB   4
`endif
`ifndef R_LAST
`define R_LAST  31
`endif
`ifndef R_COUNT
`define R_COUNT 32
`endif
`ifndef XBUS
`define XBUS    31:0
`endif

package wb_scheduler_pkg;

  localparam int unsigned REG_LAST  = `R_LAST;
  localparam int unsigned REG_COUNT = `R_COUNT;

  typedef logic [`R_MSB:0]     reg_idx_t;
  typedef logic [`XBUS]        xdata_t;
  typedef logic [`R_COUNT-1:0] reg_mask_t;

  // Writeback source; also the round-robin favour pointer encoding.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   data;
  } wb_req_t;

  // One-hot scoreboard mask for a register index. Register 0 is never
  // tracked, so its bit is always cleared here.
  function automatic reg_mask_t reg_mask(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    m[0]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_scheduler_if.sv
// wb_scheduler_if: issue, writeback-request and register-file-write bundle.
//   master: decode / execution units / register file side (testbench)
//   slave : wb_scheduler
//   iss_*      issue request and hazard-free ready
//   alu_*/lsu_* writeback requests with combinational grants
//   wr_*       registered register-file write port, wb_err sticky error
interface wb_scheduler_if;
  import wb_scheduler_pkg::*;

  logic     iss_valid;
  logic     iss_ready;
  reg_idx_t iss_rd;
  reg_idx_t iss_rs1;
  reg_idx_t iss_rs2;

  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  xdata_t   alu_data;

  logic     lsu_valid;
  logic     lsu_ready;
  reg_idx_t lsu_rd;
  xdata_t   lsu_data;

  logic     wr_en;
  reg_idx_t wr_addr;
  xdata_t   wr_data;
  logic     wb_err;

  modport master (
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  iss_ready, alu_ready, lsu_ready,
    input  wr_en, wr_addr, wr_data, wb_err
  );

  modport slave (
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output iss_ready, alu_ready, lsu_ready,
    output wr_en, wr_addr, wr_data, wb_err
  );
endinterface

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: 2-way writeback arbiter, index 0 = ALU, index 1 = LSU.
//   clk, rst : clock, asynchronous active-high reset
//   valid[1:0]: requests
//   grant[1:0]: combinational one-hot (or zero) grant, forced 0 in reset
//   RR_EN     : 1 = alternate on contention, 0 = ALU always wins
module wb_rr_arb
  import wb_scheduler_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Source to favour on the next contended cycle.
  wb_src_e favour_q;

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    if (!rst) begin
      if (valid == 2'b11) begin
        grant = (RR_EN && favour_q == SRC_LSU) ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  // Pointer moves only when someone is actually granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favour_q <= SRC_ALU;
    end else if (grant[0]) begin
      favour_q <= SRC_LSU;
    end else if (grant[1]) begin
      favour_q <= SRC_ALU;
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// wb_scheduler: register scoreboard plus writeback arbitration.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_scheduler_if.slave
//     iss_ready  = no source/destination of the presented instruction busy
//     alu/lsu_ready = combinational grant from wb_rr_arb
//     wr_en/addr/data registered one cycle after the grant
//     wb_err     sticky: a writeback hit a register that was not busy
//   RR_EN    : passed to the arbiter
module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  wb_scheduler_if.slave   bus
);

  reg_mask_t busy_q;
  logic      wr_en_q;
  reg_idx_t  wr_addr_q;
  xdata_t    wr_data_q;
  logic      wb_err_q;

  logic [1:0] req;
  logic [1:0] gnt;
  wb_req_t    sel;
  logic       iss_fire;
  logic       wb_write;
  reg_mask_t  set_mask;
  reg_mask_t  clr_mask;

  assign req = {bus.lsu_valid, bus.alu_valid};

  wb_rr_arb #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req),
    .grant (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];

  // busy_q[0] is never set, so register 0 never blocks issue.
  assign bus.iss_ready = !(busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] |
                           busy_q[bus.iss_rd]);

  assign sel      = gnt[1] ? '{rd: bus.lsu_rd, data: bus.lsu_data}
                           : '{rd: bus.alu_rd, data: bus.alu_data};
  assign iss_fire = bus.iss_valid && bus.iss_ready;
  // A grant to register 0 is consumed but never written.
  assign wb_write = (gnt != 2'b00) && (sel.rd != '0);

  // Clear follows the register-file commit edge, i.e. the edge that ends
  // the cycle in which wr_en is high. Set and clear can only coincide on
  // different indices, so both masks apply independently.
  assign set_mask = iss_fire ? reg_mask(bus.iss_rd) : '0;
  assign clr_mask = wr_en_q  ? reg_mask(wr_addr_q)  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless
      // of statement or block order.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: address/data are reset only because they must read zero during
      // reset; a pure datapath register would normally be left unreset.
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      wr_en_q <= wb_write;
      if (wb_write) begin
        wr_addr_q <= sel.rd;
        wr_data_q <= sel.data;
        if (!busy_q[sel.rd]) begin
          wb_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wb_err  = wb_err_q;

endmodule
